// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Holds the arbitration state encoding and default bus widths.
package dmem_arb_pkg;

    typedef enum logic {
        S_CORE = 1'b0,
        S_DMA  = 1'b1
    } arb_state_e;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;
    localparam int STAT_W     = 32;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Core/DMA arbiter for the single-ported data memory: core priority with a
// fairness counter that forces bounded DMA bursts. Stats under DMEM_ARB_STATS_EN.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int MAX_CORE_RUN = 8,
    parameter int BURST_LEN    = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_stall,

    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic [DATA_W-1:0] dma_rdata,

    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic [STAT_W-1:0] stat_core_stall_cnt,
    output logic [STAT_W-1:0] stat_dma_beats
);

    localparam int RUN_W  = $clog2(MAX_CORE_RUN + 1);
    localparam int BEAT_W = $clog2(BURST_LEN + 1);

    localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(MAX_CORE_RUN - 1);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_LEN - 1);

    arb_state_e        state, state_n;
    logic [RUN_W-1:0]  run_cnt, run_cnt_n;
    logic [BEAT_W-1:0] beat_cnt, beat_cnt_n;
    logic              core_gnt;

    // Grants are masked during reset so no memory write can slip through.
    // NOTE: every always_comb output gets a default first; a missed branch
    // would otherwise infer a latch.
    always_comb begin
        core_gnt = 1'b0;
        dma_gnt  = 1'b0;
        if (!rst) begin
            case (state)
                S_CORE: begin
                    core_gnt = core_req;
                    dma_gnt  = dma_req & ~core_req;
                end
                S_DMA: begin
                    core_gnt = 1'b0;
                    dma_gnt  = dma_req;
                end
            endcase
        end
    end

    assign core_stall = core_req & ~core_gnt & ~rst;

    always_comb begin
        mem_we    = (core_gnt & core_we) | (dma_gnt & dma_we);
        mem_addr  = dma_gnt ? dma_addr  : core_addr;
        mem_wdata = dma_gnt ? dma_wdata : core_wdata;
    end

    assign core_rdata = mem_rdata;
    assign dma_rdata  = mem_rdata;

    always_comb begin
        state_n    = state;
        run_cnt_n  = run_cnt;
        beat_cnt_n = beat_cnt;
        case (state)
            S_CORE: begin
                // An opportunistic DMA beat (core idle) leaves beat_cnt alone.
                if (core_gnt && dma_req) begin
                    if (run_cnt == RUN_LAST) begin
                        state_n    = S_DMA;
                        run_cnt_n  = '0;
                        beat_cnt_n = '0;
                    end else begin
                        run_cnt_n = run_cnt + RUN_W'(1);
                    end
                end else begin
                    run_cnt_n = '0;
                end
            end
            S_DMA: begin
                if (!dma_req || (beat_cnt == BEAT_LAST)) begin
                    state_n    = S_CORE;
                    beat_cnt_n = '0;
                end else begin
                    beat_cnt_n = beat_cnt + BEAT_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_CORE;
            run_cnt  <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_n;
            run_cnt  <= run_cnt_n;
            beat_cnt <= beat_cnt_n;
        end
    end

`ifdef DMEM_ARB_STATS_EN
    sat_counter #(.WIDTH(STAT_W)) u_stall_cnt (
        .clk   (clk),
        .clr   (rst),
        .inc   (core_stall),
        .count (stat_core_stall_cnt)
    );

    sat_counter #(.WIDTH(STAT_W)) u_beat_cnt (
        .clk   (clk),
        .clr   (rst),
        .inc   (dma_gnt),
        .count (stat_dma_beats)
    );
`else
    assign stat_core_stall_cnt = '0;
    assign stat_dma_beats      = '0;
`endif

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-ported data memory between two requesters: the pipeline memory stage (core) and a DMA/loader port (dma).
- The core has priority by default. A fairness counter forces a bounded DMA burst after the core has held the memory continuously while the DMA was waiting.
- Sits between the memory stage and the data memory. It drives the memory's write enable, address and write data, and returns read data to whichever requester holds the grant.
- The memory read is combinational and the write is synchronous, so a granted access completes in the same cycle.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MAX_CORE_RUN, 8, consecutive core grants allowed while dma_req is pending before the DMA is forced in (must be ≥ 1).
- BURST_LEN, 4, maximum DMA grants per forced burst (must be ≥ 1).

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- core_req  input  1  core access request (load or store in the memory stage).
- core_we  input  1  core write enable.
- core_addr  input  ADDR_W  core address.
- core_wdata  input  DATA_W  core write data.
- core_rdata  output  DATA_W  read data to the core; equals mem_rdata.
- core_stall  output  1  core request not served this cycle; the pipeline must hold.
- dma_req  input  1  DMA access request.
- dma_we  input  1  DMA write enable.
- dma_addr  input  ADDR_W  DMA address.
- dma_wdata  input  DATA_W  DMA write data.
- dma_gnt  output  1  DMA access is performed this cycle.
- dma_rdata  output  DATA_W  read data to the DMA; equals mem_rdata.
- mem_we  output  1  to data memory writeEnable.
- mem_addr  output  ADDR_W  to data memory address.
- mem_wdata  output  DATA_W  to data memory writeData.
- mem_rdata  input  DATA_W  from data memory readData.
- stat_core_stall_cnt  output  32  stall statistics (see Optional Feature).
- stat_dma_beats  output  32  DMA beat statistics (see Optional Feature).

Behaviour:
- Registered state:
  - FSM {S_CORE, S_DMA}.
  - run_cnt, width clog2(MAX_CORE_RUN+1).
  - beat_cnt, width clog2(BURST_LEN+1).
- Grants are combinational from state and requests.
- S_CORE:
  - core_gnt = core_req.
  - dma_gnt = dma_req & ~core_req.
- S_DMA:
  - dma_gnt = dma_req.
  - core_gnt = 0.
- Derived outputs:
  - core_stall = core_req & ~core_gnt.
  - Memory mux selects dma when dma_gnt is high, else core.
  - mem_we = (core_gnt & core_we) | (dma_gnt & dma_we).
  - mem_addr and mem_wdata are muxed; when neither requester is granted they carry the core values with mem_we = 0.
- While rst = 1:
  - core_gnt = dma_gnt = mem_we = core_stall = 0.
  - On the edge: state ← S_CORE, run_cnt ← 0, beat_cnt ← 0.
  - Reset mid-burst aborts the burst; no memory write occurs during reset cycles.
- run_cnt, in S_CORE:
  - Increments when core_gnt & dma_req.
  - Clears when dma_req = 0 or core_req = 0.
- S_CORE → S_DMA when core_gnt & dma_req & run_cnt == MAX_CORE_RUN-1. On the transition, run_cnt ← 0 and beat_cnt ← 0.
- A DMA grant in S_CORE (core idle) is an opportunistic single beat: no state change, and beat_cnt is untouched.
- beat_cnt, in S_DMA: increments on each dma_gnt.
- S_DMA → S_CORE, with beat_cnt ← 0, when either:
  - dma_gnt & beat_cnt == BURST_LEN-1, or
  - dma_req = 0 (the burst is abandoned and that cycle's core request is still stalled).
- Latency is zero for a granted access; read data is valid in the grant cycle.
- The maximum core stall caused by the DMA is BURST_LEN cycles per MAX_CORE_RUN core grants.

Optional Feature:
- Macro DMEM_ARB_STATS_EN.
- When defined:
  - stat_core_stall_cnt increments on every cycle with core_stall = 1.
  - stat_dma_beats increments on every dma_gnt.
  - Both are 32-bit and saturate at 0xFFFFFFFF.
  - Both clear on rst.
- When undefined: both ports are driven constant 0 and no counter logic is instantiated.

Decomposition:
- Package dmem_arb_pkg holds:
  - the state enum (S_CORE, S_DMA);
  - default ADDR_W and DATA_W;
  - the stats counter width constant (32).
- One sub-module, sat_counter (parameterised width, synchronous clear, saturating increment), instantiated twice under DMEM_ARB_STATS_EN.

Test Plan (MAX_CORE_RUN=4, BURST_LEN=2 unless noted):
- Reset: rst=1 for 2 cycles with core_req=dma_req=1, core_we=1 → mem_we=0, dma_gnt=0, core_stall=0. After release, the FSM is in S_CORE and stats read 0.
- Core only: write 0xDEADBEEF to 0x10, then read 0x10 → core_stall=0 both cycles, mem_we=1 only in the first, core_rdata=0xDEADBEEF in the second.
- DMA only, core idle 3 cycles: dma_req=1 writing 0x20/0x24/0x28 → dma_gnt=1 each cycle, state stays S_CORE, beat_cnt=0.
- Sustained contention: both request from cycle 0 → core granted cycles 0–3, dma_gnt cycles 4–5 with core_stall=1, core cycles 6–9, DMA 10–11. With stats enabled, stat_core_stall_cnt=4 at cycle 12.
- DMA drops mid-burst: enter S_DMA, dma_req=0 on the second burst cycle → dma_gnt=0 and core_stall=1 that cycle; next cycle S_CORE with core granted and beat_cnt=0.
- Reset during S_DMA: assert rst for 1 cycle after the first burst beat → no grant in the reset cycle; next cycle S_CORE, core granted, run_cnt=0.
